// File: rtl/fifo_bus_param.sv
// Single-clock synchronous FIFO with registered read port and occupancy flags.
// Define FIFO_BUS_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module fifo_bus_param #(
   parameter int DATA_LEN  = 16,
   parameter int DEPTH     = 16,
   parameter int ADDR_LEN  = $clog2(DEPTH),
   parameter int AF_MARGIN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                wr_en,
   input  logic                rd_en,
   output logic [DATA_LEN-1:0] rd_data,
   output logic                rd_valid,
   output logic                full,
   output logic                almost_full,
   output logic                empty,
   output logic [ADDR_LEN:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam logic [ADDR_LEN:0] FULL_LVL = (ADDR_LEN+1)'(DEPTH);
   localparam logic [ADDR_LEN:0] AF_LVL   = (ADDR_LEN+1)'(DEPTH - AF_MARGIN);

   logic [DATA_LEN-1:0] mem [DEPTH];
   logic [ADDR_LEN-1:0] wr_ptr;
   logic [ADDR_LEN-1:0] rd_ptr;
   logic                wr_ok;
   logic                rd_ok;

   // Flags come straight off the registered count: no extra latency.
   assign full        = (count == FULL_LVL);
   assign almost_full = (count >= AF_LVL);
   assign empty       = (count == '0);

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok && !rst)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_BUS_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)
            overflow <= 1'b1;
         if (rd_en && empty)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_bus_param.sv
// Directed self-checking bench for fifo_bus_param (DEPTH=8, AF_MARGIN=2).
// Expected error-flag value follows FIFO_BUS_ERR_FLAGS_EN.
module tb_fifo_bus_param;

   localparam int DW = 16;
   localparam int DP = 8;
   localparam int AW = 3;

`ifdef FIFO_BUS_ERR_FLAGS_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          almost_full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int n_chk  = 0;
   int n_pass = 0;

   fifo_bus_param #(
      .DATA_LEN (DW),
      .DEPTH    (DP),
      .AF_MARGIN(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .full       (full),
      .almost_full(almost_full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_rvalid", 32'(rd_valid), 0);
      chk("rst_rdata", 32'(rd_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);

      // fill 0x0001..0x0008
      for (int i = 1; i <= 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 16'(i);
         tick();
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_af", 32'(almost_full), 32'(i >= 6));
         chk("fill_full", 32'(full), 32'(i == 8));
         chk("fill_empty", 32'(empty), 0);
      end

      // write while full is dropped
      wr_data = 16'hDEAD;
      tick();
      wr_en = 1'b0;
      chk("ovf_count", 32'(count), 8);
      chk("ovf_full", 32'(full), 1);
      chk("ovf_flag", 32'(overflow), 32'(ERR));

      // drain in order
      for (int i = 1; i <= 8; i++) begin
         rd_en = 1'b1;
         tick();
         chk("drain_valid", 32'(rd_valid), 1);
         chk("drain_data", 32'(rd_data), 32'(i));
         chk("drain_count", 32'(count), 32'(8 - i));
      end
      rd_en = 1'b0;
      tick();
      chk("idle_valid", 32'(rd_valid), 0);
      chk("idle_hold", 32'(rd_data), 8);
      chk("idle_empty", 32'(empty), 1);

      // read while empty is ignored
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("udf_valid", 32'(rd_valid), 0);
      chk("udf_hold", 32'(rd_data), 8);
      chk("udf_count", 32'(count), 0);
      chk("udf_flag", 32'(underflow), 32'(ERR));
      chk("udf_ovf_sticky", 32'(overflow), 32'(ERR));

      // simultaneous wr/rd while empty: write only, no bypass
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 16'h00AA;
      tick();
      wr_en = 1'b0;
      chk("se_count", 32'(count), 1);
      chk("se_valid", 32'(rd_valid), 0);
      tick();
      rd_en = 1'b0;
      chk("se_rd_valid", 32'(rd_valid), 1);
      chk("se_rd_data", 32'(rd_data), 32'h00AA);
      chk("se_rd_count", 32'(count), 0);

      // prime to count 3, then 20 simultaneous wr/rd across wrap
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         wr_data = 16'(32'h100 + i);
         tick();
      end
      chk("prime_count", 32'(count), 3);
      rd_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         wr_data = 16'(32'h103 + k);
         tick();
         chk("stream_count", 32'(count), 3);
         chk("stream_valid", 32'(rd_valid), 1);
         chk("stream_data", 32'(rd_data), 32'h100 + 32'(k));
      end
      rd_en = 1'b0;

      // refill to full, then simultaneous wr/rd: read only
      for (int i = 0; i < 5; i++) begin
         wr_data = 16'(32'h200 + i);
         tick();
      end
      chk("refill_full", 32'(full), 1);
      wr_data = 16'hBEEF;
      rd_en   = 1'b1;
      tick();
      chk("sf_count", 32'(count), 7);
      chk("sf_data", 32'(rd_data), 32'h114);
      chk("sf_valid", 32'(rd_valid), 1);
      wr_en = 1'b0;
      tick();
      tick();
      rd_en = 1'b0;
      chk("pre_rst_data", 32'(rd_data), 32'h116);
      chk("pre_rst_count", 32'(count), 5);

      // reset mid-operation wins over wr/rd
      rst     = 1'b1;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 16'h5555;
      tick();
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("mrst_count", 32'(count), 0);
      chk("mrst_empty", 32'(empty), 1);
      chk("mrst_valid", 32'(rd_valid), 0);
      chk("mrst_data", 32'(rd_data), 0);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_udf", 32'(underflow), 0);
      chk("mrst_full", 32'(full), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_bus_param.md
FIFO_BUS_PARAM -- requirements
Module: fifo_bus_param

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, giving the data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, giving the storage entries (power of two, >=4).
REQ-003 SHALL have parameter ADDR_LEN, default log2(DEPTH), giving the pointer width.
REQ-004 SHALL have parameter AF_MARGIN, default 4, giving the free-entry threshold for almost_full (1..DEPTH-1).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port wr_data, input, DATA_LEN bits: write word.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port rd_en, input, 1 bit: read request.
REQ-010 SHALL have port rd_data, output, DATA_LEN bits: registered read word.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data holds a newly read word this cycle.
REQ-012 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 SHALL have port almost_full, output, 1 bit: count >= DEPTH-AF_MARGIN.
REQ-014 SHALL have port empty, output, 1 bit: count == 0.
REQ-015 SHALL have port count, output, ADDR_LEN+1 bits: current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow, output, 1 bit: sticky error flag, per Configuration.
REQ-017 SHALL have port underflow, output, 1 bit: sticky error flag, per Configuration.

Function
REQ-018 SHALL accept a write when wr_en=1 and full=0; the word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-019 SHALL accept a read when rd_en=1 and empty=0; rd_data <= mem[rd_ptr] at that edge, rd_valid=1 the next cycle, and rd_ptr increments modulo DEPTH.
REQ-020 SHALL keep rd_valid=0 and hold rd_data in every cycle following an edge with no accepted read.
REQ-021 SHALL drop a write attempted while full=1, leaving memory, wr_ptr and count unchanged.
REQ-022 SHALL ignore a read attempted while empty=1, leaving rd_ptr, rd_data and count unchanged.
REQ-023 SHALL update count +1 on write-only, -1 on read-only, and leave it unchanged on an accepted simultaneous read and write.
REQ-024 SHALL, on simultaneous wr_en and rd_en while full, accept only the read (count DEPTH -> DEPTH-1).
REQ-025 SHALL, on simultaneous wr_en and rd_en while empty, accept only the write (count 0 -> 1, rd_valid stays 0).
REQ-026 SHALL use all DEPTH entries, with no reserved guard slots.
REQ-027 SHALL derive full, almost_full and empty from the registered count, so that they reflect the state after the last edge with zero added latency.
REQ-028 SHALL make a written word readable no earlier than the cycle after its write edge (no write-to-read bypass).
REQ-029 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0 with no data corruption.

Reset
REQ-030 SHALL, while rst=1 at an edge, set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0; memory contents are not reset.
REQ-031 SHALL give rst priority over simultaneous wr_en/rd_en, discarding in-flight data when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, when FIFO_BUS_ERR_FLAGS_EN is defined, set overflow on any dropped write and underflow on any ignored read, each held at 1 until rst.
REQ-033 SHALL, when FIFO_BUS_ERR_FLAGS_EN is undefined, tie overflow and underflow to constant 0 with no flag registers, leaving all other behaviour unchanged.

Verification (DATA_LEN=16, DEPTH=8, AF_MARGIN=2)
REQ-034 SHALL check: after reset, write 0x0001..0x0008 on consecutive cycles -> count=8, full=1, almost_full=1 from count=6 onward, empty=0.
REQ-035 SHALL check: from full, read 8 consecutive times -> rd_data=0x0001..0x0008 in order, each with rd_valid=1 one cycle after rd_en, then empty=1 and count=0.
REQ-036 SHALL check: while full, wr_en=1 with wr_data=0xDEAD -> count stays 8, 0xDEAD is never read, and overflow=1 when FIFO_BUS_ERR_FLAGS_EN is defined (else 0).
REQ-037 SHALL check: while empty, wr_en=1 and rd_en=1 with wr_data=0x00AA -> count=1, rd_valid=0; on the next rd_en, rd_data=0x00AA.
REQ-038 SHALL check: 20 writes interleaved with reads at count 3 (simultaneous wr/rd) -> count stays 3, output order matches input order, and pointers wrap correctly.
REQ-039 SHALL check: rst=1 at count=5 alongside wr_en/rd_en -> next cycle count=0, empty=1, rd_valid=0, rd_data=0, and flags cleared.
